// File: rtl/mem_port_arbiter_if.sv
// Core-side and memory-side signal bundle for the fetch/load-store memory port arbiter.
// The arbiter takes the slave view; the core and memory together form the master view.
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        m_we;
    logic [31:0] m_a;
    logic [31:0] m_wd;
    logic [3:0]  m_wm;
    logic [31:0] m_rd;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_funct3, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output m_we, m_a, m_wd, m_wm,
        input  m_rd
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_funct3, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  m_we, m_a, m_wd, m_wm,
        output m_rd
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-ported byte-masked memory between instruction fetch and load/store,
// with store lane steering, load extension and registered one-cycle responses.
module mem_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]  starve_cnt_reg;
    logic [3:0]  starve_cnt_next;
    logic        i_rvalid_reg;
    logic [31:0] i_rdata_reg;
    logic        d_rvalid_reg;
    logic [31:0] d_rdata_reg;
    logic        d_err_reg;

    logic        starve_hit;
    logic        i_gnt;
    logic        d_gnt;

    logic [1:0]  off;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        is_unsigned;
    logic        f3_legal;
    logic        misaligned;
    logic        d_err_now;
    logic        legal_store;

    logic [3:0]  base_mask;
    logic [3:0]  lane_mask;
    logic [31:0] lane_wd;
    logic [7:0]  rd_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] load_val;

    logic        m_we;
    logic [31:0] m_a;
    logic [31:0] m_wd;
    logic [3:0]  m_wm;

    assign off = bus.d_addr[1:0];

    // Grants are suppressed during reset so nothing is written and no response is queued.
    assign starve_hit = (starve_cnt_reg == STARVE_LIM);
    assign i_gnt      = !reset && bus.i_req && (!bus.d_req || starve_hit);
    assign d_gnt      = !reset && bus.d_req && !i_gnt;

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (i_gnt || !bus.i_req) begin
            starve_cnt_next = 4'd0;
        end else if (d_gnt && !starve_hit) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end
    end

    always_comb begin
        is_byte     = 1'b0;
        is_half     = 1'b0;
        is_word     = 1'b0;
        is_unsigned = 1'b0;
        f3_legal    = 1'b0;
        case (bus.d_funct3)
            3'b000: begin is_byte = 1'b1; f3_legal = 1'b1; end
            3'b001: begin is_half = 1'b1; f3_legal = 1'b1; end
            3'b010: begin is_word = 1'b1; f3_legal = 1'b1; end
            3'b100: begin is_byte = 1'b1; is_unsigned = 1'b1; f3_legal = !bus.d_we; end
            3'b101: begin is_half = 1'b1; is_unsigned = 1'b1; f3_legal = !bus.d_we; end
            default: f3_legal = 1'b0;
        endcase
    end

    assign misaligned  = (is_half && off[0]) || (is_word && (off != 2'b00));
    assign d_err_now   = !f3_legal || misaligned;
    assign legal_store = bus.d_we && !d_err_now;

    always_comb begin
        base_mask = 4'b0000;
        if (is_byte) begin
            base_mask = 4'b0001;
        end else if (is_half) begin
            base_mask = 4'b0011;
        end else if (is_word) begin
            base_mask = 4'b1111;
        end
    end

    assign lane_mask = base_mask << off;

    // Store data is replicated across lanes so the mask alone picks the destination bytes.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rd_byte[gi] = bus.m_rd[8*gi +: 8];
            assign lane_wd[8*gi +: 8] = is_byte ? bus.d_wdata[7:0] :
                                        is_half ? bus.d_wdata[8*(gi%2) +: 8] :
                                                  bus.d_wdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = rd_byte[off];
    assign sel_half = off[1] ? bus.m_rd[31:16] : bus.m_rd[15:0];

    always_comb begin
        load_val = bus.m_rd;
        if (is_byte) begin
            load_val = {{24{!is_unsigned && sel_byte[7]}}, sel_byte};
        end else if (is_half) begin
            load_val = {{16{!is_unsigned && sel_half[15]}}, sel_half};
        end
    end

    always_comb begin
        m_we = 1'b0;
        m_a  = 32'h0;
        m_wd = 32'h0;
        m_wm = 4'b0000;
        if (i_gnt) begin
            m_a = bus.i_addr;
        end else if (d_gnt) begin
            m_a = bus.d_addr;
            if (bus.d_we) begin
                m_wd = lane_wd;
            end
            if (legal_store) begin
                m_we = 1'b1;
                m_wm = lane_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_reg <= 4'd0;
            i_rvalid_reg   <= 1'b0;
            i_rdata_reg    <= 32'h0;
            d_rvalid_reg   <= 1'b0;
            d_rdata_reg    <= 32'h0;
            d_err_reg      <= 1'b0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            i_rvalid_reg   <= i_gnt;
            d_rvalid_reg   <= d_gnt;
            d_err_reg      <= d_gnt && d_err_now;
            if (i_gnt) begin
                i_rdata_reg <= bus.m_rd;
            end
            if (d_gnt) begin
                d_rdata_reg <= (bus.d_we || d_err_now) ? 32'h0 : load_val;
            end
        end
    end

    assign bus.i_gnt    = i_gnt;
    assign bus.i_rvalid = i_rvalid_reg;
    assign bus.i_rdata  = i_rdata_reg;
    assign bus.d_gnt    = d_gnt;
    assign bus.d_rvalid = d_rvalid_reg;
    assign bus.d_rdata  = d_rdata_reg;
    assign bus.d_err    = d_err_reg;
    assign bus.m_we     = m_we;
    assign bus.m_a      = m_a;
    assign bus.m_wd     = m_wd;
    assign bus.m_wm     = m_wm;

endmodule
